// File: rtl/tinker_mem_pkg.sv
// tinker_mem_pkg
//   Shared definitions for the Tinker memory responder: request opcode
//   encodings, responder FSM states, default array size and per-op
//   transfer lengths.
package tinker_mem_pkg;

    localparam logic [1:0] OP_FETCH = 2'b00;  // 4-byte instruction fetch
    localparam logic [1:0] OP_LOAD  = 2'b01;  // 8-byte data read
    localparam logic [1:0] OP_STORE = 2'b10;  // 8-byte data write
    localparam logic [1:0] OP_RSVD  = 2'b11;  // reserved, answered with an error

    localparam int DEFAULT_MEM_SIZE = 524288;
    localparam int INSTR_BYTES      = 4;
    localparam int DATA_BYTES       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/tinker_byte_array.sv
// tinker_byte_array
//   Single-port byte RAM backing the Tinker von Neumann memory.
//   One synchronous 1-byte write per clock, combinational 1-byte read of the
//   same address. Contents are never cleared.
// Ports:
//   clk    - clock
//   we     - write enable for the current edge
//   addr   - byte address (shared by read and write)
//   wdata  - byte to store
//   rdata  - byte currently held at addr
module tinker_byte_array
    import tinker_mem_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] bytes [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            bytes[addr] <= wdata;
        end
    end

    assign rdata = bytes[addr];

endmodule

// File: rtl/tinker_mem_responder.sv
// tinker_mem_responder
//   Valid/ready memory slave for the Tinker core. Serves 4-byte fetches and
//   8-byte loads/stores against one big-endian byte array, moving one byte
//   per clock after LATENCY wait cycles. One request in flight at a time.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_op                - 00 fetch, 01 load, 10 store, 11 reserved
//   req_addr              - address of the most significant byte
//   req_wdata             - store data
//   resp_valid/resp_ready - response handshake
//   resp_rdata            - read data (fetch zero-extended), 0 otherwise
//   resp_err              - request rejected, memory untouched
module tinker_mem_responder
    import tinker_mem_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          state;
    logic [1:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic [63:0]     wdata_q;
    logic [2:0]      last_idx;
    logic [2:0]      idx;
    logic [CW-1:0]   cnt;

    logic [3:0]      req_bytes;
    logic [64:0]     end_addr;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;

    assign req_ready  = (state == ST_IDLE) && !reset;
    assign resp_valid = (state == ST_RESP);

    // End address is formed in 65 bits so a request near 2^64 cannot wrap
    // around and look in range.
    always_comb begin
        req_bytes = (req_op == OP_FETCH) ? 4'(INSTR_BYTES) : 4'(DATA_BYTES);
        end_addr  = {1'b0, req_addr} + 65'(req_bytes);
    end

    // Range check at accept guarantees addr_q + idx stays inside the array.
    assign mem_addr  = addr_q + AW'(idx);
    assign mem_we    = (state == ST_XFER) && (op_q == OP_STORE);
    // Store byte idx is the big-endian byte: bits [8*(7-idx) +: 8].
    assign mem_wdata = wdata_q[{3'd7 - idx, 3'b000} +: 8];

    tinker_byte_array #(
        .MEM_SIZE (MEM_SIZE),
        .AW       (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Request capture: data-only registers, meaningful once accepted.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            op_q     <= req_op;
            addr_q   <= req_addr[AW-1:0];
            wdata_q  <= req_wdata;
            last_idx <= (req_op == OP_FETCH) ? 3'(INSTR_BYTES - 1) : 3'(DATA_BYTES - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            cnt        <= '0;
            idx        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        resp_rdata <= '0;
                        if (req_op == OP_RSVD || end_addr > 65'(MEM_SIZE)) begin
                            resp_err <= 1'b1;
                            state    <= ST_RESP;
                        end else if (LATENCY > 0) begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= ST_WAIT;
                        end else begin
                            idx   <= '0;
                            state <= ST_XFER;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        idx   <= '0;
                        state <= ST_XFER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_XFER: begin
                    // Reads shift in LSB-first, so after N bytes the first
                    // byte sits highest and a fetch is already zero-extended.
                    if (op_q != OP_STORE) begin
                        resp_rdata <= {resp_rdata[55:0], mem_rdata};
                    end
                    if (idx == last_idx) begin
                        state <= ST_RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_err <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinker_mem_responder.sv
module tb_tinker_mem_responder;

    localparam int MS_A  = 524288;
    localparam int LAT_A = 2;
    localparam int MS_B  = 4096;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_a = 1'b0;
    logic        req_valid_b = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready_a, resp_valid_a, resp_err_a;
    logic [63:0] resp_rdata_a;
    logic        req_ready_b, resp_valid_b, resp_err_b;
    logic [63:0] resp_rdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tinker_mem_responder #(.MEM_SIZE(MS_A), .LATENCY(LAT_A)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_a),
        .req_ready  (req_ready_a),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid_a),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata_a),
        .resp_err   (resp_err_a)
    );

    tinker_mem_responder #(.MEM_SIZE(MS_B), .LATENCY(LAT_B)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b)
    );

    // Reference model: plain byte map of the big array plus the
    // response rules (error check, latency formula, big-endian assembly).
    logic [7:0] mdl [logic [63:0]];

    function automatic int nbytes(input logic [1:0] op);
        return (op == 2'b00) ? 4 : 8;
    endfunction

    function automatic logic mdl_err(input logic [1:0] op, input logic [63:0] a, input int ms);
        logic [64:0] e;
        e = {1'b0, a} + 65'(nbytes(op));
        return (op == 2'b11) || (e > 65'(ms));
    endfunction

    function automatic int mdl_edges(input logic err, input logic [1:0] op, input int lat);
        return err ? 1 : 1 + lat + nbytes(op);
    endfunction

    function automatic logic [63:0] mdl_read(input logic [1:0] op, input logic [63:0] a);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nbytes(op); k++) begin
            v = (v << 8) | 64'(mdl.exists(a + 64'(k)) ? mdl[a + 64'(k)] : 8'h00);
        end
        return v;
    endfunction

    task automatic mdl_write(input logic [63:0] a, input logic [63:0] wd, input int n);
        for (int k = 0; k < n; k++) begin
            mdl[a + 64'(k)] = wd[63 - 8*k -: 8];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One complete transaction on DUT a (sel=0) or b (sel=1). edges counts
    // rising edges from the accept edge (inclusive) until resp_valid is seen.
    task automatic txn(input bit sel, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] rd,
                       output logic e, output int edges);
        @(negedge clk);
        chk("req_ready_idle", 64'(sel ? req_ready_b : req_ready_a), 64'd1);
        req_op = op; req_addr = a; req_wdata = wd; resp_ready = 1'b0;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        edges = 1;
        while (!(sel ? resp_valid_b : resp_valid_a) && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        rd = sel ? resp_rdata_b : resp_rdata_a;
        e  = sel ? resp_err_b : resp_err_a;
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_edges;
    } vec_t;

    vec_t tbl [12];

    initial begin : main
        logic [63:0] rd;
        logic        e;
        int          edges;
        logic [63:0] exp_rd;

        tbl[0]  = '{2'b10, 64'h1000, 64'h0123456789ABCDEF, 64'h0, 1'b0, 11};
        tbl[1]  = '{2'b01, 64'h1000, 64'h0, 64'h0123456789ABCDEF, 1'b0, 11};
        tbl[2]  = '{2'b10, 64'h2000, 64'h123456789ABCDEF0, 64'h0, 1'b0, 11};
        tbl[3]  = '{2'b00, 64'h2000, 64'h0, 64'h0000000012345678, 1'b0, 7};
        tbl[4]  = '{2'b00, 64'h1003, 64'h0, 64'h000000006789ABCD, 1'b0, 7};
        tbl[5]  = '{2'b01, 64'(MS_A - 4), 64'h0, 64'h0, 1'b1, 1};
        tbl[6]  = '{2'b11, 64'h1000, 64'h0, 64'h0, 1'b1, 1};
        tbl[7]  = '{2'b10, 64'(MS_A - 8), 64'hCAFEF00DDEADBEEF, 64'h0, 1'b0, 11};
        tbl[8]  = '{2'b10, 64'(MS_A - 1), 64'h1111111111111111, 64'h0, 1'b1, 1};
        tbl[9]  = '{2'b01, 64'(MS_A - 8), 64'h0, 64'hCAFEF00DDEADBEEF, 1'b0, 11};
        tbl[10] = '{2'b00, 64'(MS_A - 4), 64'h0, 64'h00000000DEADBEEF, 1'b0, 7};
        tbl[11] = '{2'b01, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1, 1};

        // Reset state while reset is held
        #3;
        chk("rst_req_ready", 64'(req_ready_a), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_a), 64'd0);
        chk("rst_resp_err", 64'(resp_err_a), 64'd0);
        chk("rst_resp_rdata", resp_rdata_a, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", 64'(req_ready_a), 64'd1);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            txn(1'b0, tbl[i].op, tbl[i].addr, tbl[i].wdata, rd, e, edges);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
            chk($sformatf("vec%0d_edges", i), 64'(edges), 64'(tbl[i].exp_edges));
            if (tbl[i].op == 2'b10 && !tbl[i].exp_err) mdl_write(tbl[i].addr, tbl[i].wdata, 8);
        end

        // Zero-latency instance
        txn(1'b1, 2'b10, 64'h100, 64'h123456789ABCDEF0, rd, e, edges);
        chk("lat0_store_edges", 64'(edges), 64'd9);
        txn(1'b1, 2'b00, 64'h100, 64'h0, rd, e, edges);
        chk("lat0_fetch_edges", 64'(edges), 64'd5);
        chk("lat0_fetch_rdata", rd, 64'h0000000012345678);
        txn(1'b1, 2'b01, 64'(MS_B - 7), 64'h0, rd, e, edges);
        chk("lat0_err_edges", 64'(edges), 64'd1);
        chk("lat0_err_flag", 64'(e), 64'd1);

        // Backpressure: response held 5 cycles with resp_ready low
        @(negedge clk);
        req_op = 2'b01; req_addr = 64'h1000; req_valid_a = 1'b1;
        @(posedge clk); #1; req_valid_a = 1'b0;
        edges = 1;
        while (!resp_valid_a && edges < 200) begin @(posedge clk); #1; edges++; end
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(resp_valid_a), 64'd1);
            chk("bp_rdata", resp_rdata_a, 64'h0123456789ABCDEF);
            chk("bp_err", 64'(resp_err_a), 64'd0);
            chk("bp_req_ready", 64'(req_ready_a), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        chk("bp_valid_drop", 64'(resp_valid_a), 64'd0);
        chk("bp_ready_rise", 64'(req_ready_a), 64'd1);

        // Asynchronous reset in the middle of a cycle while a response is held
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            req_op = (t == 0) ? 2'b01 : 2'b11; req_addr = 64'h2000; req_valid_a = 1'b1;
            @(posedge clk); #1; req_valid_a = 1'b0;
            edges = 1;
            while (!resp_valid_a && edges < 200) begin @(posedge clk); #1; edges++; end
            #2; reset = 1'b1; #1;
            chk("mid_rst_valid", 64'(resp_valid_a), 64'd0);
            chk("mid_rst_err", 64'(resp_err_a), 64'd0);
            chk("mid_rst_rdata", resp_rdata_a, 64'd0);
            chk("mid_rst_ready", 64'(req_ready_a), 64'd0);
            @(negedge clk); reset = 1'b0; #1;
            chk("mid_rst_ready_after", 64'(req_ready_a), 64'd1);
        end

        // Reset during a store after three byte writes
        txn(1'b0, 2'b10, 64'h3000, 64'h0, rd, e, edges);
        mdl_write(64'h3000, 64'h0, 8);
        @(negedge clk);
        req_op = 2'b10; req_addr = 64'h3000; req_wdata = 64'hAABBCCDDEEFF0011; req_valid_a = 1'b1;
        @(posedge clk); #1; req_valid_a = 1'b0;
        repeat (5) @(posedge clk);
        #1; reset = 1'b1; #1;
        chk("abort_valid", 64'(resp_valid_a), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 64'(resp_valid_a), 64'd0);
        end
        mdl_write(64'h3000, 64'hAABBCC0000000000, 3);
        txn(1'b0, 2'b01, 64'h3000, 64'h0, rd, e, edges);
        chk("abort_mem", rd, mdl_read(2'b01, 64'h3000));
        chk("abort_mem_const", rd, 64'hAABBCC0000000000);

        // Randomized traffic against the model
        for (int i = 0; i < 32; i++) begin
            logic [63:0] wd;
            wd = {$urandom, $urandom};
            txn(1'b0, 2'b10, 64'h4000 + 64'(8*i), wd, rd, e, edges);
            mdl_write(64'h4000 + 64'(8*i), wd, 8);
        end
        for (int i = 0; i < 80; i++) begin
            logic [1:0]  op;
            logic [63:0] a, wd;
            logic        xe;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = 64'(MS_A) - 64'($urandom_range(1, 8));
            else a = 64'h4000 + 64'($urandom_range(0, 248));
            wd = {$urandom, $urandom};
            xe = mdl_err(op, a, MS_A);
            exp_rd = (xe || op == 2'b10) ? 64'h0 : mdl_read(op, a);
            txn(1'b0, op, a, wd, rd, e, edges);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_err", i), 64'(e), 64'(xe));
            chk($sformatf("rnd%0d_edges", i), 64'(edges), 64'(mdl_edges(xe, op, LAT_A)));
            if (!xe && op == 2'b10) mdl_write(a, wd, 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
